// File: rtl/btn_cmd_arbiter.sv
// Arbitrates latched button requests (INC/DEC/CLR/LOAD) into a single
// valid/ready command stream for an up/down counter.
//
// Handshake: cmd_valid, cmd_op and cmd_data are held stable while cmd_valid=1
// and cmd_ready=0. A command transfers on the rising edge where both are 1.
// cmd_valid never drops without a transfer unless reset is asserted.
module btn_cmd_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   tick,
    input  logic [W-1:0] load_val,
    output logic         cmd_valid,
    output logic [1:0]   cmd_op,
    output logic [W-1:0] cmd_data,
    input  logic         cmd_ready,
    output logic [3:0]   pend,
    output logic [3:0]   ovf,
    output logic         o_dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [1:0] OP_INC  = 2'b00;
    localparam logic [1:0] OP_DEC  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t       r_state;
    state_t       w_state_next;
    logic [3:0]   r_pend;
    logic [3:0]   r_ovf;
    logic         r_cmd_valid;
    logic [1:0]   r_cmd_op;
    logic [W-1:0] r_cmd_data;
    logic [1:0]   r_rr_last;

    logic         w_grant_en;
    logic         w_retire;
    logic [1:0]   w_win_idx;
    logic [3:0]   w_grant_vec;
    logic         w_rr_found;
    logic [1:0]   w_rr_idx;

    // Opcode equals the tick bit index, so the winner index doubles as cmd_op.
    function automatic logic [2:0] rr_pick(
        input logic [3:0] p,
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        logic [2:0] res;
        res = 3'b000;
        if (p[a]) begin
            res = {1'b1, a};
        end else if (p[b]) begin
            res = {1'b1, b};
        end else if (p[c]) begin
            res = {1'b1, c};
        end
        return res;
    endfunction

    // Round-robin over INC, DEC, LOAD; search starts after the last granted one.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = OP_INC;
        case (r_rr_last)
            OP_INC:  {w_rr_found, w_rr_idx} = rr_pick(r_pend, OP_DEC, OP_LOAD, OP_INC);
            OP_DEC:  {w_rr_found, w_rr_idx} = rr_pick(r_pend, OP_LOAD, OP_INC, OP_DEC);
            default: {w_rr_found, w_rr_idx} = rr_pick(r_pend, OP_INC, OP_DEC, OP_LOAD);
        endcase
    end

    always_comb begin
        w_win_idx = w_rr_idx;
        if (r_pend[2]) begin
            w_win_idx = OP_CLR;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pend != 4'b0000) begin
                    w_grant_en   = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    if (r_pend != 4'b0000) begin
                        w_grant_en = 1'b1;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_grant_vec = 4'b0000;
        if (w_grant_en) begin
            case (w_win_idx)
                2'd0:    w_grant_vec = 4'b0001;
                2'd1:    w_grant_vec = 4'b0010;
                2'd2:    w_grant_vec = 4'b0100;
                default: w_grant_vec = 4'b1000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A tick on the bit being granted this edge re-arms it as a fresh request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= 4'b0000;
            r_ovf  <= 4'b0000;
        end else begin
            r_pend <= tick | (r_pend & ~w_grant_vec);
            r_ovf  <= r_ovf | (tick & r_pend & ~w_grant_vec);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_INC;
            r_cmd_data  <= '0;
            r_rr_last   <= OP_LOAD;
        end else if (w_grant_en) begin
            r_cmd_valid <= 1'b1;
            r_cmd_op    <= w_win_idx;
            r_cmd_data  <= (w_win_idx == OP_LOAD) ? load_val : '0;
            if (w_win_idx != OP_CLR) begin
                r_rr_last <= w_win_idx;
            end
        end else if (w_retire) begin
            r_cmd_valid <= 1'b0;
            r_cmd_op    <= OP_INC;
            r_cmd_data  <= '0;
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_op      = r_cmd_op;
    assign cmd_data    = r_cmd_data;
    assign pend        = r_pend;
    assign ovf         = r_ovf;
    assign o_dbg_state = (r_state == ST_ISSUE);

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Directed bench for btn_cmd_arbiter: per-edge vector table plus hand-written
// sequences for fairness and reset during an outstanding command.
module tb_btn_cmd_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] tick;
    logic [3:0] load_val;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic       cmd_ready;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic       o_dbg_state;

    int n_checks;
    int n_pass;

    btn_cmd_arbiter #(.W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .load_val   (load_val),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .pend       (pend),
        .ovf        (ovf),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tick;
        logic [3:0] lv;
        logic       rdy;
        logic       v;
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] pend;
        logic [3:0] ovf;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];
    logic [1:0] exp_q[$];

    function automatic vec_t mk(input logic [3:0] t, input logic [3:0] lv, input logic rdy,
                                input logic v, input logic [1:0] op, input logic [3:0] d,
                                input logic [3:0] p, input logic [3:0] o);
        vec_t r;
        r.tick = t; r.lv = lv; r.rdy = rdy; r.v = v;
        r.op = op; r.data = d; r.pend = p; r.ovf = o;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] t, input logic [3:0] lv, input logic rdy);
        tick      = t;
        load_val  = lv;
        cmd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       got_clr_seen;
        logic [1:0] exp_op;
        int         n_clr;
        int         n_grants;
        int         waited;

        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        tick      = 4'b0000;
        load_val  = 4'd0;
        cmd_ready = 1'b0;

        // Each row: inputs for one edge, then outputs expected just after it.
        vecs[0]  = mk(4'b1111, 4'd6, 1'b1, 1'b0, 2'b00, 4'd0, 4'b1111, 4'b0000);
        vecs[1]  = mk(4'b0000, 4'd6, 1'b1, 1'b1, 2'b10, 4'd0, 4'b1011, 4'b0000);
        vecs[2]  = mk(4'b0000, 4'd6, 1'b1, 1'b1, 2'b00, 4'd0, 4'b1010, 4'b0000);
        vecs[3]  = mk(4'b0000, 4'd6, 1'b1, 1'b1, 2'b01, 4'd0, 4'b1000, 4'b0000);
        vecs[4]  = mk(4'b0000, 4'd6, 1'b1, 1'b1, 2'b11, 4'd6, 4'b0000, 4'b0000);
        vecs[5]  = mk(4'b0000, 4'd6, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0000, 4'b0000);
        vecs[6]  = mk(4'b0001, 4'd6, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0001, 4'b0000);
        vecs[7]  = mk(4'b0000, 4'd6, 1'b1, 1'b1, 2'b00, 4'd0, 4'b0000, 4'b0000);
        vecs[8]  = mk(4'b0000, 4'd6, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0000, 4'b0000);
        vecs[9]  = mk(4'b1000, 4'd5, 1'b0, 1'b0, 2'b00, 4'd0, 4'b1000, 4'b0000);
        vecs[10] = mk(4'b0000, 4'd5, 1'b0, 1'b1, 2'b11, 4'd5, 4'b0000, 4'b0000);
        vecs[11] = mk(4'b0000, 4'd9, 1'b0, 1'b1, 2'b11, 4'd5, 4'b0000, 4'b0000);
        vecs[12] = mk(4'b0000, 4'd9, 1'b0, 1'b1, 2'b11, 4'd5, 4'b0000, 4'b0000);
        vecs[13] = mk(4'b0000, 4'd9, 1'b0, 1'b1, 2'b11, 4'd5, 4'b0000, 4'b0000);
        vecs[14] = mk(4'b0000, 4'd9, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0000, 4'b0000);
        vecs[15] = mk(4'b0100, 4'd0, 1'b0, 1'b0, 2'b00, 4'd0, 4'b0100, 4'b0000);
        vecs[16] = mk(4'b0010, 4'd0, 1'b0, 1'b1, 2'b10, 4'd0, 4'b0010, 4'b0000);
        vecs[17] = mk(4'b0000, 4'd0, 1'b0, 1'b1, 2'b10, 4'd0, 4'b0010, 4'b0000);
        vecs[18] = mk(4'b0010, 4'd0, 1'b0, 1'b1, 2'b10, 4'd0, 4'b0010, 4'b0010);
        vecs[19] = mk(4'b0000, 4'd0, 1'b0, 1'b1, 2'b10, 4'd0, 4'b0010, 4'b0010);
        vecs[20] = mk(4'b0000, 4'd0, 1'b1, 1'b1, 2'b01, 4'd0, 4'b0000, 4'b0010);
        vecs[21] = mk(4'b0000, 4'd0, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0000, 4'b0010);
        vecs[22] = mk(4'b0000, 4'd0, 1'b1, 1'b0, 2'b00, 4'd0, 4'b0000, 4'b0010);

        // Asynchronous reset assertion, checked before any clock edge.
        #2 reset = 1'b0;
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_op", 32'(cmd_op), 32'd0);
        chk("rst_data", 32'(cmd_data), 32'd0);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].tick, vecs[i].lv, vecs[i].rdy);
            chk($sformatf("v%0d_valid", i), 32'(cmd_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_op", i), 32'(cmd_op), 32'(vecs[i].op));
            chk($sformatf("v%0d_data", i), 32'(cmd_data), 32'(vecs[i].data));
            chk($sformatf("v%0d_pend", i), 32'(pend), 32'(vecs[i].pend));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
        end

        // Fairness: INC and DEC backlogged, one CLR injected mid-stream.
        exp_op = 2'b00;
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(exp_op);
            exp_op = (exp_op == 2'b00) ? 2'b01 : 2'b00;
        end
        n_clr    = 0;
        n_grants = 0;
        for (int c = 0; c < 12; c++) begin
            step((c == 5) ? 4'b0111 : 4'b0011, 4'd0, 1'b1);
            if (cmd_valid) begin
                if (cmd_op == 2'b10) begin
                    n_clr++;
                end else begin
                    n_grants++;
                    chk($sformatf("fair_op%0d", n_grants), 32'(cmd_op), 32'(exp_q.pop_front()));
                end
            end
        end
        waited = 0;
        got_clr_seen = 1'b0;
        while (cmd_valid && waited < 10) begin
            step(4'b0000, 4'd0, 1'b1);
            waited++;
            if (cmd_valid) begin
                if (cmd_op == 2'b10) begin
                    n_clr++;
                    got_clr_seen = 1'b1;
                end else begin
                    n_grants++;
                    chk($sformatf("fair_op%0d", n_grants), 32'(cmd_op), 32'(exp_q.pop_front()));
                end
            end
        end
        chk("fair_drained", 32'(cmd_valid), 32'd0);
        chk("fair_clr_count", 32'(n_clr), 32'd1);
        chk("fair_clr_late", 32'(got_clr_seen), 32'd0);
        chk("fair_grants", 32'(n_grants), 32'd12);

        // Reset while a LOAD is held under backpressure.
        step(4'b1000, 4'd7, 1'b0);
        waited = 0;
        while (!cmd_valid && waited < 5) begin
            step(4'b0000, 4'd7, 1'b0);
            waited++;
        end
        chk("mid_valid_before", 32'(cmd_valid), 32'd1);
        step(4'b0001, 4'd7, 1'b0);
        chk("mid_pend_before", 32'(pend), 32'b0001);
        tick = 4'b0000;
        #3 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_pend", 32'(pend), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_data", 32'(cmd_data), 32'd0);
        chk("mid_rst_state", 32'(o_dbg_state), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step(4'b0000, 4'd7, 1'b1);
            chk($sformatf("post_rst_valid%0d", c), 32'(cmd_valid), 32'd0);
            chk($sformatf("post_rst_pend%0d", c), 32'(pend), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
